// File: rtl/fetch_decode_issue.sv
//==============================================================================
// fetch_decode_issue : dual-slot instruction fetch and decode, three issue lines
// Revision 1.0 : initial release
//==============================================================================
`default_nettype none

module fetch_decode_issue #(
  parameter int IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_we,
  input  logic [5:0]  imem_waddr,
  input  logic [31:0] imem_wdata,
  input  logic [7:0]  pc,
  output logic [31:0] inst1,
  output logic [31:0] inst2,
  output logic [4:0]  rs1_1, rs2_1, rd_1,
  output logic [31:0] imm_1,
  output logic [6:0]  opcode_1,
  output logic [2:0]  alu_op_1,
  output logic        alu_src_1, mem_to_reg_1, reg_write_1, mem_read_1, mem_write_1,
  output logic [4:0]  rs1_2, rs2_2, rd_2,
  output logic [31:0] imm_2,
  output logic [6:0]  opcode_2,
  output logic [2:0]  alu_op_2,
  output logic        alu_src_2, mem_to_reg_2, reg_write_2, mem_read_2, mem_write_2,
  input  logic        valid_1, valid_2, valid_3,
  input  logic [2:0]  iss_alu_op_1, iss_alu_op_2, iss_alu_op_3,
  input  logic [6:0]  iss_opcode_1, iss_opcode_2, iss_opcode_3,
  input  logic [31:0] opa_1, opa_2, opa_3,
  input  logic [31:0] opb_1, opb_2, opb_3,
  input  logic [31:0] iss_imm_1, iss_imm_2, iss_imm_3,
  output logic [5:0]  dmem_addr,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] val_1, val_2, val_3,
  output logic [2:0]  fu_done
);

  localparam logic [6:0] C_OP_R  = 7'b0110011;
  localparam logic [6:0] C_OP_I  = 7'b0010011;
  localparam logic [6:0] C_OP_LW = 7'b0000011;
  localparam logic [6:0] C_OP_SW = 7'b0100011;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } dec_t;

  function automatic logic [2:0] alu_sel(input logic [2:0] f3, input logic f7b, input logic is_r);
    case (f3)
      3'b000:  alu_sel = (is_r && f7b) ? 3'b001 : 3'b000;
      3'b001:  alu_sel = 3'b110;
      3'b100:  alu_sel = 3'b100;
      3'b101:  alu_sel = f7b ? 3'b101 : 3'b111;
      3'b110:  alu_sel = 3'b011;
      3'b111:  alu_sel = 3'b010;
      default: alu_sel = 3'b000;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d        = '0;
    d.rs1    = inst[19:15];
    d.rs2    = inst[24:20];
    d.rd     = inst[11:7];
    d.opcode = inst[6:0];
    case (inst[6:0])
      C_OP_R: begin
        d.reg_write = 1'b1;
        d.alu_op    = alu_sel(inst[14:12], inst[30], 1'b1);
      end
      C_OP_I: begin
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
        d.imm       = {{20{inst[31]}}, inst[31:20]};
        d.alu_op    = alu_sel(inst[14:12], inst[30], 1'b0);
      end
      C_OP_LW: begin
        d.alu_src    = 1'b1;
        d.mem_read   = 1'b1;
        d.mem_to_reg = 1'b1;
        d.reg_write  = 1'b1;
        d.imm        = {{20{inst[31]}}, inst[31:20]};
      end
      C_OP_SW: begin
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
        d.imm       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  alu = a + b;
      3'b001:  alu = a - b;
      3'b010:  alu = a & b;
      3'b011:  alu = a | b;
      3'b100:  alu = a ^ b;
      3'b101:  alu = 32'($signed(a) >>> b[4:0]);
      3'b110:  alu = a << b[4:0];
      default: alu = a >> b[4:0];
    endcase
  endfunction

  function automatic logic uses_imm(input logic [6:0] opc);
    return (opc == C_OP_I) || (opc == C_OP_LW) || (opc == C_OP_SW);
  endfunction

  // Lines 1 and 2 have no memory port, so loads/stores collapse to an add.
  function automatic logic [31:0] alu_line(input logic [6:0] opc, input logic [2:0] op,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] imm);
    logic [2:0] eff_op;
    eff_op = ((opc == C_OP_LW) || (opc == C_OP_SW)) ? 3'b000 : op;
    return alu(eff_op, a, uses_imm(opc) ? imm : b);
  endfunction

  logic [31:0] imem [IMEM_WORDS];
  logic [5:0]  fidx1, fidx2;
  logic [31:0] inst1_d, inst1_q, inst2_d, inst2_q;
  logic [31:0] val1_d, val1_q, val2_d, val2_q, val3_d, val3_q;
  logic [2:0]  fu_done_d, fu_done_q;
  logic [7:0]  ea3;
  logic [31:0] res3;
  logic        unused_bits;
  dec_t        dec1, dec2;

  assign fidx1 = 6'(32'(pc[7:2]) % IMEM_WORDS);
  assign fidx2 = 6'((32'(pc[7:2]) + 32'd1) % IMEM_WORDS);

  // Array is read before the write lands, so a same-cycle write/fetch sees old data.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  assign ea3         = opa_3[7:0] + iss_imm_3[7:0];
  assign dmem_addr   = ea3[7:2];
  assign unused_bits = ^{pc[1:0], ea3[1:0]};

  always_comb begin
    inst1_d   = imem[fidx1];
    inst2_d   = imem[fidx2];
    fu_done_d = {valid_3, valid_2, valid_1};
    case (iss_opcode_3)
      C_OP_LW: res3 = dmem_rdata;
      C_OP_SW: res3 = opb_3;
      default: res3 = alu_line(iss_opcode_3, iss_alu_op_3, opa_3, opb_3, iss_imm_3);
    endcase
    val1_d = valid_1 ? alu_line(iss_opcode_1, iss_alu_op_1, opa_1, opb_1, iss_imm_1) : val1_q;
    val2_d = valid_2 ? alu_line(iss_opcode_2, iss_alu_op_2, opa_2, opb_2, iss_imm_2) : val2_q;
    val3_d = valid_3 ? res3 : val3_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst1_q   <= '0;
      inst2_q   <= '0;
      val1_q    <= '0;
      val2_q    <= '0;
      val3_q    <= '0;
      fu_done_q <= '0;
    end else begin
      inst1_q   <= inst1_d;
      inst2_q   <= inst2_d;
      val1_q    <= val1_d;
      val2_q    <= val2_d;
      val3_q    <= val3_d;
      fu_done_q <= fu_done_d;
    end
  end

  assign dec1 = decode(inst1_q);
  assign dec2 = decode(inst2_q);

  assign inst1   = inst1_q;
  assign inst2   = inst2_q;
  assign val_1   = val1_q;
  assign val_2   = val2_q;
  assign val_3   = val3_q;
  assign fu_done = fu_done_q;

  assign {rs1_1, rs2_1, rd_1, imm_1, opcode_1, alu_op_1,
          alu_src_1, mem_to_reg_1, reg_write_1, mem_read_1, mem_write_1} = dec1;
  assign {rs1_2, rs2_2, rd_2, imm_2, opcode_2, alu_op_2,
          alu_src_2, mem_to_reg_2, reg_write_2, mem_read_2, mem_write_2} = dec2;

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_issue.sv
//==============================================================================
// tb_fetch_decode_issue : randomized self-checking bench for fetch_decode_issue
// Revision 1.0 : initial release
//==============================================================================
`default_nettype none

module tb_fetch_decode_issue;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [7:0]  pc;
  logic [31:0] inst1, inst2;
  logic [4:0]  rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2;
  logic [31:0] imm_1, imm_2;
  logic [6:0]  opcode_1, opcode_2;
  logic [2:0]  alu_op_1, alu_op_2;
  logic        alu_src_1, mem_to_reg_1, reg_write_1, mem_read_1, mem_write_1;
  logic        alu_src_2, mem_to_reg_2, reg_write_2, mem_read_2, mem_write_2;
  logic        valid_1, valid_2, valid_3;
  logic [2:0]  iss_alu_op_1, iss_alu_op_2, iss_alu_op_3;
  logic [6:0]  iss_opcode_1, iss_opcode_2, iss_opcode_3;
  logic [31:0] opa_1, opa_2, opa_3, opb_1, opb_2, opb_3;
  logic [31:0] iss_imm_1, iss_imm_2, iss_imm_3;
  logic [5:0]  dmem_addr;
  logic [31:0] dmem_rdata;
  logic [31:0] val_1, val_2, val_3;
  logic [2:0]  fu_done;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem_m [64];
  logic [31:0] v_m   [3];

  always #5 clk = ~clk;

  fetch_decode_issue #(.IMEM_WORDS(64)) dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc(pc), .inst1(inst1), .inst2(inst2),
    .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1), .imm_1(imm_1), .opcode_1(opcode_1),
    .alu_op_1(alu_op_1), .alu_src_1(alu_src_1), .mem_to_reg_1(mem_to_reg_1),
    .reg_write_1(reg_write_1), .mem_read_1(mem_read_1), .mem_write_1(mem_write_1),
    .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2), .imm_2(imm_2), .opcode_2(opcode_2),
    .alu_op_2(alu_op_2), .alu_src_2(alu_src_2), .mem_to_reg_2(mem_to_reg_2),
    .reg_write_2(reg_write_2), .mem_read_2(mem_read_2), .mem_write_2(mem_write_2),
    .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
    .iss_alu_op_1(iss_alu_op_1), .iss_alu_op_2(iss_alu_op_2), .iss_alu_op_3(iss_alu_op_3),
    .iss_opcode_1(iss_opcode_1), .iss_opcode_2(iss_opcode_2), .iss_opcode_3(iss_opcode_3),
    .opa_1(opa_1), .opa_2(opa_2), .opa_3(opa_3), .opb_1(opb_1), .opb_2(opb_2), .opb_3(opb_3),
    .iss_imm_1(iss_imm_1), .iss_imm_2(iss_imm_2), .iss_imm_3(iss_imm_3),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .val_1(val_1), .val_2(val_2), .val_3(val_3), .fu_done(fu_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t obs1();
    return '{rs1:rs1_1, rs2:rs2_1, rd:rd_1, imm:imm_1, opcode:opcode_1, alu_op:alu_op_1,
             alu_src:alu_src_1, mem_to_reg:mem_to_reg_1, reg_write:reg_write_1,
             mem_read:mem_read_1, mem_write:mem_write_1};
  endfunction

  function automatic exp_t obs2();
    return '{rs1:rs1_2, rs2:rs2_2, rd:rd_2, imm:imm_2, opcode:opcode_2, alu_op:alu_op_2,
             alu_src:alu_src_2, mem_to_reg:mem_to_reg_2, reg_write:reg_write_2,
             mem_read:mem_read_2, mem_write:mem_write_2};
  endfunction

  // Reference decode: mnemonic lookup table indexed by funct3, then the two
  // funct7-qualified exceptions (sub, sra/srai).
  function automatic logic [2:0] ref_aluop(input int f3, input bit b30, input bit is_r);
    logic [2:0] tbl [8];
    tbl = '{3'd0, 3'd6, 3'd0, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
    if (f3 == 5 && b30) return 3'd5;
    if (f3 == 0 && b30 && is_r) return 3'd1;
    return tbl[f3];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int   imm_i, imm_s;
    e        = '0;
    e.rs1    = w[19:15];
    e.rs2    = w[24:20];
    e.rd     = w[11:7];
    e.opcode = w[6:0];
    imm_i = int'(w[31:20]);
    if (imm_i >= 2048) imm_i -= 4096;
    imm_s = int'({w[31:25], w[11:7]});
    if (imm_s >= 2048) imm_s -= 4096;
    if (w[6:0] == 7'h33) begin
      e.reg_write = 1'b1;
      e.alu_op    = ref_aluop(int'(w[14:12]), w[30], 1'b1);
    end else if (w[6:0] == 7'h13) begin
      e.alu_src = 1'b1; e.reg_write = 1'b1; e.imm = 32'(imm_i);
      e.alu_op  = ref_aluop(int'(w[14:12]), w[30], 1'b0);
    end else if (w[6:0] == 7'h03) begin
      e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
      e.imm     = 32'(imm_i);
    end else if (w[6:0] == 7'h23) begin
      e.alu_src = 1'b1; e.mem_write = 1'b1; e.imm = 32'(imm_s);
    end
    return e;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ones, fill;
    int sh;
    sh   = int'(b[4:0]);
    ones = 32'hFFFF_FFFF;
    fill = a[31] ? ~(ones >> sh) : 32'h0;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a >> sh) | fill;
      3'd6: return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  function automatic bit is_mem_op(input logic [6:0] opc);
    return opc == 7'h03 || opc == 7'h23;
  endfunction

  function automatic logic [31:0] operand_b(input logic [6:0] opc, input logic [31:0] b, input logic [31:0] imm);
    return (opc == 7'h13 || is_mem_op(opc)) ? imm : b;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: op = 7'h23;
      4: op = r[6:0];
      default: return 32'h0;
    endcase
    return {r[31:7], op};
  endfunction

  function automatic logic [6:0] gen_opcode();
    case ($urandom_range(0, 4))
      0: return 7'h33;
      1: return 7'h13;
      2: return 7'h03;
      3: return 7'h23;
      default: return 7'h37;
    endcase
  endfunction

  task automatic write_word(input int a, input logic [31:0] d);
    imem_we    = 1'b1;
    imem_waddr = 6'(a);
    imem_wdata = d;
    tick();
    imem_we    = 1'b0;
    mem_m[a]   = d;
  endtask

  task automatic idle_lines();
    valid_1 = 0; valid_2 = 0; valid_3 = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (inst1 !== 32'h0) begin bad++; $display("FAIL rst_inst1 got=%h exp=0", inst1); end
    total++; if (inst2 !== 32'h0) begin bad++; $display("FAIL rst_inst2 got=%h exp=0", inst2); end
    total++; if ({val_1, val_2, val_3} !== 96'h0) begin bad++; $display("FAIL rst_vals got=%h %h %h exp=0", val_1, val_2, val_3); end
    total++; if (fu_done !== 3'b000) begin bad++; $display("FAIL rst_fu_done got=%b exp=000", fu_done); end
    total++; if (obs1() !== exp_t'(0)) begin bad++; $display("FAIL rst_dec1 got=%h exp=0", obs1()); end
    total++; if (obs2() !== exp_t'(0)) begin bad++; $display("FAIL rst_dec2 got=%h exp=0", obs2()); end
    // Memory loads are accepted while reset is held; no fetch happens yet.
    for (int i = 0; i < 64; i++) write_word(i, gen_inst());
    total++; if (inst1 !== 32'h0) begin bad++; $display("FAIL rst_nofetch got=%h exp=0", inst1); end
  endtask

  task automatic test_fetch_decode();
    exp_t e;
    write_word(0, 32'h0050_0093);
    write_word(1, 32'h0020_81B3);
    write_word(2, 32'h0020_A423);
    write_word(3, 32'h0040_A283);
    pc    = 8'd0;
    reset = 1'b0;
    tick();
    e = '{rs1:5'd0, rs2:5'd5, rd:5'd1, imm:32'd5, opcode:7'h13, alu_op:3'd0, alu_src:1'b1,
          mem_to_reg:1'b0, reg_write:1'b1, mem_read:1'b0, mem_write:1'b0};
    total++; if (obs1() !== e) begin bad++; $display("FAIL addi_slot1 got=%h exp=%h", obs1(), e); end
    e = '{rs1:5'd1, rs2:5'd2, rd:5'd3, imm:32'd0, opcode:7'h33, alu_op:3'd0, alu_src:1'b0,
          mem_to_reg:1'b0, reg_write:1'b1, mem_read:1'b0, mem_write:1'b0};
    total++; if (obs2() !== e) begin bad++; $display("FAIL add_slot2 got=%h exp=%h", obs2(), e); end
    pc = 8'd8;
    tick();
    e = '{rs1:5'd1, rs2:5'd2, rd:5'd8, imm:32'd8, opcode:7'h23, alu_op:3'd0, alu_src:1'b1,
          mem_to_reg:1'b0, reg_write:1'b0, mem_read:1'b0, mem_write:1'b1};
    total++; if (obs1() !== e) begin bad++; $display("FAIL sw_slot1 got=%h exp=%h", obs1(), e); end
    e = '{rs1:5'd1, rs2:5'd4, rd:5'd5, imm:32'd4, opcode:7'h03, alu_op:3'd0, alu_src:1'b1,
          mem_to_reg:1'b1, reg_write:1'b1, mem_read:1'b1, mem_write:1'b0};
    total++; if (obs2() !== e) begin bad++; $display("FAIL lw_slot2 got=%h exp=%h", obs2(), e); end
  endtask

  task automatic test_wrap();
    write_word(63, 32'hAAAA_5513);
    write_word(0,  32'hBBBB_0033);
    pc = 8'd252;
    tick();
    total++; if (inst1 !== 32'hAAAA_5513) begin bad++; $display("FAIL wrap_inst1 got=%h exp=AAAA5513", inst1); end
    total++; if (inst2 !== 32'hBBBB_0033) begin bad++; $display("FAIL wrap_inst2 got=%h exp=BBBB0033", inst2); end
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] old_w, new_w;
    old_w = mem_m[12];
    new_w = ~old_w;
    pc = 8'd48;
    write_word(12, new_w);
    total++; if (inst1 !== old_w) begin bad++; $display("FAIL rw_old got=%h exp=%h", inst1, old_w); end
    tick();
    total++; if (inst1 !== new_w) begin bad++; $display("FAIL rw_new got=%h exp=%h", inst1, new_w); end
  endtask

  task automatic test_decode_random();
    int k, k2;
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 63);
      k2 = (k + 1) % 64;
      write_word(k, gen_inst());
      pc = 8'((k * 4) + $urandom_range(0, 3));
      tick();
      total++; if (inst1 !== mem_m[k] || obs1() !== ref_decode(mem_m[k])) begin
        bad++; $display("FAIL rnd_dec1 idx=%0d got=%h exp=%h", k, obs1(), ref_decode(mem_m[k]));
      end
      total++; if (inst2 !== mem_m[k2] || obs2() !== ref_decode(mem_m[k2])) begin
        bad++; $display("FAIL rnd_dec2 idx=%0d got=%h exp=%h", k2, obs2(), ref_decode(mem_m[k2]));
      end
    end
  endtask

  task automatic test_issue_directed();
    valid_1 = 1; iss_opcode_1 = 7'h33; iss_alu_op_1 = 3'd1; opa_1 = 32'd3; opb_1 = 32'd5; iss_imm_1 = 32'h0;
    valid_2 = 1; iss_opcode_2 = 7'h33; iss_alu_op_2 = 3'd5; opa_2 = 32'h8000_0000; opb_2 = 32'd4; iss_imm_2 = 32'h0;
    valid_3 = 0;
    tick();
    v_m[0] = 32'hFFFF_FFFE; v_m[1] = 32'hF800_0000;
    total++; if (val_1 !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_val1 got=%h exp=FFFFFFFE", val_1); end
    total++; if (val_2 !== 32'hF800_0000) begin bad++; $display("FAIL sra_val2 got=%h exp=F8000000", val_2); end
    total++; if (fu_done !== 3'b011) begin bad++; $display("FAIL done_011 got=%b exp=011", fu_done); end
    valid_1 = 0; valid_2 = 0;
    valid_3 = 1; iss_opcode_3 = 7'h03; iss_alu_op_3 = 3'd0; opa_3 = 32'h10; iss_imm_3 = 32'd4; opb_3 = 32'h1234;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (dmem_addr !== 6'd5) begin bad++; $display("FAIL lw_addr got=%0d exp=5", dmem_addr); end
    tick();
    v_m[2] = 32'hDEAD_BEEF;
    total++; if (val_3 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_val3 got=%h exp=DEADBEEF", val_3); end
    total++; if (fu_done !== 3'b100) begin bad++; $display("FAIL done_100 got=%b exp=100", fu_done); end
    total++; if (val_1 !== v_m[0] || val_2 !== v_m[1]) begin
      bad++; $display("FAIL hold_12 got=%h %h exp=%h %h", val_1, val_2, v_m[0], v_m[1]);
    end
  endtask

  task automatic test_issue_random();
    logic [31:0] ea, nv [3];
    for (int n = 0; n < 60; n++) begin
      valid_1 = 1'($urandom); valid_2 = 1'($urandom); valid_3 = 1'($urandom);
      iss_opcode_1 = gen_opcode(); iss_opcode_2 = gen_opcode(); iss_opcode_3 = gen_opcode();
      iss_alu_op_1 = 3'($urandom); iss_alu_op_2 = 3'($urandom); iss_alu_op_3 = 3'($urandom);
      opa_1 = $urandom; opa_2 = $urandom; opa_3 = $urandom;
      opb_1 = $urandom; opb_2 = $urandom; opb_3 = $urandom;
      iss_imm_1 = $urandom; iss_imm_2 = $urandom; iss_imm_3 = $urandom;
      ea = opa_3 + iss_imm_3;
      dmem_rdata = $urandom ^ {26'h0, ea[7:2]};
      nv[0] = ref_alu(is_mem_op(iss_opcode_1) ? 3'd0 : iss_alu_op_1, opa_1, operand_b(iss_opcode_1, opb_1, iss_imm_1));
      nv[1] = ref_alu(is_mem_op(iss_opcode_2) ? 3'd0 : iss_alu_op_2, opa_2, operand_b(iss_opcode_2, opb_2, iss_imm_2));
      if (iss_opcode_3 == 7'h03)      nv[2] = dmem_rdata;
      else if (iss_opcode_3 == 7'h23) nv[2] = opb_3;
      else nv[2] = ref_alu(iss_alu_op_3, opa_3, operand_b(iss_opcode_3, opb_3, iss_imm_3));
      #1;
      total++; if (dmem_addr !== ea[7:2]) begin bad++; $display("FAIL rnd_addr got=%0d exp=%0d", dmem_addr, ea[7:2]); end
      tick();
      if (valid_1) v_m[0] = nv[0];
      if (valid_2) v_m[1] = nv[1];
      if (valid_3) v_m[2] = nv[2];
      total++; if (val_1 !== v_m[0]) begin bad++; $display("FAIL rnd_val1 op=%h got=%h exp=%h", iss_opcode_1, val_1, v_m[0]); end
      total++; if (val_2 !== v_m[1]) begin bad++; $display("FAIL rnd_val2 op=%h got=%h exp=%h", iss_opcode_2, val_2, v_m[1]); end
      total++; if (val_3 !== v_m[2]) begin bad++; $display("FAIL rnd_val3 op=%h got=%h exp=%h", iss_opcode_3, val_3, v_m[2]); end
      total++; if (fu_done !== {valid_3, valid_2, valid_1}) begin
        bad++; $display("FAIL rnd_done got=%b exp=%b", fu_done, {valid_3, valid_2, valid_1});
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] w10;
    valid_1 = 1; valid_2 = 1; valid_3 = 1;
    pc = 8'd40;
    tick();
    reset = 1'b1;
    tick();
    total++; if ({inst1, inst2} !== 64'h0) begin bad++; $display("FAIL mrst_inst got=%h %h exp=0", inst1, inst2); end
    total++; if ({val_1, val_2, val_3} !== 96'h0) begin bad++; $display("FAIL mrst_vals got=%h %h %h exp=0", val_1, val_2, val_3); end
    total++; if (fu_done !== 3'b000) begin bad++; $display("FAIL mrst_done got=%b exp=000", fu_done); end
    total++; if (obs1() !== exp_t'(0) || obs2() !== exp_t'(0)) begin bad++; $display("FAIL mrst_dec got=%h %h exp=0", obs1(), obs2()); end
    w10 = 32'h0040_A283;
    write_word(10, w10);
    idle_lines();
    reset = 1'b0;
    tick();
    v_m[0] = 0; v_m[1] = 0; v_m[2] = 0;
    total++; if (inst1 !== w10) begin bad++; $display("FAIL refetch1 got=%h exp=%h", inst1, w10); end
    total++; if (inst2 !== mem_m[11]) begin bad++; $display("FAIL refetch2 got=%h exp=%h", inst2, mem_m[11]); end
    total++; if ({val_1, val_2, val_3, fu_done} !== 99'h0) begin bad++; $display("FAIL post_rst_vals got=%h %h %h %b exp=0", val_1, val_2, val_3, fu_done); end
  endtask

  initial begin
    reset = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; pc = '0;
    valid_1 = 0; valid_2 = 0; valid_3 = 0;
    iss_alu_op_1 = '0; iss_alu_op_2 = '0; iss_alu_op_3 = '0;
    iss_opcode_1 = '0; iss_opcode_2 = '0; iss_opcode_3 = '0;
    opa_1 = '0; opa_2 = '0; opa_3 = '0; opb_1 = '0; opb_2 = '0; opb_3 = '0;
    iss_imm_1 = '0; iss_imm_2 = '0; iss_imm_3 = '0; dmem_rdata = '0;
    v_m[0] = 0; v_m[1] = 0; v_m[2] = 0;
    test_reset();
    test_fetch_decode();
    test_wrap();
    test_same_cycle_write();
    test_decode_random();
    test_issue_directed();
    test_issue_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
